// File: rtl/mem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_pkg : memory-port encodings, FSM states and default widths for mem_arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
package mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int MEMOP_W    = 32;

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam logic [MEMOP_W-1:0] MEMOP_IDLE  = 32'd0;
  localparam logic [MEMOP_W-1:0] MEMOP_READ  = 32'd1;
  localparam logic [MEMOP_W-1:0] MEMOP_WRITE = 32'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Illegal requester ops map to an idle memory cycle.
  function automatic logic [MEMOP_W-1:0] memop_of(input logic [1:0] op);
    case (op)
      OP_READ:  memop_of = MEMOP_READ;
      OP_WRITE: memop_of = MEMOP_WRITE;
      default:  memop_of = MEMOP_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arb2 : combinational two-way picker, round-robin or fixed priority to port 0
// Revision 1.0
// ----------------------------------------------------------------------------
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  input  logic fixed_prio,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = req1;
    if (req0 && req1) begin
      winner = fixed_prio ? 1'b0 : ~last_grant;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter : shares one word-wide memory port between CPU (port 0) and DMA (port 1)
// Revision 1.0
// ----------------------------------------------------------------------------
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_STATES = 0,
  parameter int FIXED_PRIO  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [1:0]        op0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic [1:0]        op1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [31:0]       memop,
  output logic [ADDR_W-1:0] memaddress,
  output logic [DATA_W-1:0] memoutdata,
  input  logic [DATA_W-1:0] memindata,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t            state;
  state_t            next_state;
  logic [3:0]        wait_cnt;
  logic              last_grant;
  logic              err_flag;
  logic              is_read;
  logic              pick_valid;
  logic              pick;
  logic [1:0]        sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [31:0]       sel_memop;

  rr_arb2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .fixed_prio (FIXED_PRIO != 0),
    .valid      (pick_valid),
    .winner     (pick)
  );

  assign sel_op    = pick ? op1 : op0;
  assign sel_addr  = pick ? addr1 : addr0;
  assign sel_wdata = pick ? wdata1 : wdata0;
  assign sel_memop = memop_of(sel_op);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_valid) next_state = ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
    end
  end

  // last_grant resets to 1 so that port 0 wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memop      <= MEMOP_IDLE;
      memaddress <= '0;
      memoutdata <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= 4'd0;
      err_flag   <= 1'b0;
      is_read    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            memop      <= sel_memop;
            memaddress <= sel_addr;
            memoutdata <= sel_wdata;
            grant_id   <= pick;
            last_grant <= pick;
            wait_cnt   <= WAIT_INIT;
            err_flag   <= (sel_memop == MEMOP_IDLE);
            is_read    <= (sel_memop == MEMOP_READ);
          end
        end
        ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            memop <= MEMOP_IDLE;
            if (grant_id) begin
              ack1 <= 1'b1;
              err1 <= err_flag;
              if (is_read) rdata1 <= memindata;
            end else begin
              ack0 <= 1'b1;
              err0 <= err_flag;
              if (is_read) rdata0 <= memindata;
            end
          end
        end
        RESP: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          err0 <= 1'b0;
          err1 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single word-wide memory port (memop / memaddress / memoutdata / memindata) between two requesters.
- Port 0 is the CPU core; port 1 is a DMA or loader engine.
- Sequences each access through an issue/access/response handshake and picks the winner by round-robin, or by fixed priority when configured.
- Sits between the requesters and the memory model; it is the only driver of the memory port.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_STATES, 0, extra cycles memop is held beyond the first (0..15), for slow memories.
- FIXED_PRIO, 0, 1 = port 0 always wins contention; 0 = round-robin.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held until ack0.
- op0  in  2  port 0 operation: 1 = read, 2 = write; 0 and 3 are illegal.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  one-cycle completion pulse.
- rdata0  out  DATA_W  read data; valid while ack0 = 1.
- err0  out  1  pulses with ack0 for an illegal op.
- req1 / op1 / addr1 / wdata1 / ack1 / rdata1 / err1: identical set for port 1.
- memop  out  32  memory operation: 0 = idle, 1 = read, 2 = write.
- memaddress  out  ADDR_W  memory address.
- memoutdata  out  DATA_W  memory write data.
- memindata  in  DATA_W  memory read data; valid at the end of each cycle in which memop = 1.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  port that owns the current transaction.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. rst = 0 forces the following immediately, regardless of clk:
  - state = IDLE;
  - memop, memaddress, memoutdata, rdata0/1, ack0/1, err0/1, grant_id = 0;
  - wait counter = 0;
  - last_grant = 1, so port 0 wins the first contention.
- All outputs are registered.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise select the winner:
    - only one req high -> that port;
    - both high with FIXED_PRIO = 1 -> port 0;
    - both high with FIXED_PRIO = 0 -> the port other than last_grant.
  - At the clock edge, latch the winner's op/addr/wdata into memop/memaddress/memoutdata, set grant_id and last_grant = winner, load wait counter = WAIT_STATES, and go to ACCESS.
  - Illegal op: memop is latched as 0 (no memory access) and an err flag is recorded.
- ACCESS:
  - memop is held stable.
  - If the wait counter != 0, decrement it and stay in ACCESS.
  - Otherwise, at the edge:
    - memop <= 0;
    - if the latched op is read, rdata[grant_id] <= memindata;
    - ack[grant_id] <= 1;
    - err[grant_id] <= recorded err flag;
    - go to RESP.
- RESP:
  - ack/err are high for exactly this cycle; the requester must drop req here.
  - At the edge, clear ack/err and go to IDLE.
  - rdata holds its value until the next read completes on that port.
- Latency: (3 + WAIT_STATES) cycles from req sampled to ack high. Throughput is one transaction per (3 + WAIT_STATES) cycles.
- The losing requester keeps req high and is served next.
- With round-robin, two continuously requesting ports alternate 0,1,0,1,…
- Changes to op/addr/wdata while busy are ignored; they were latched at grant.
- A req that drops before grant is never served. A req that drops after grant still completes and is acked.
- Reset asserted mid-transaction aborts it: no ack is ever produced, and memop returns to 0 asynchronously.
- ack0 and ack1 are never high in the same cycle.
- memop is never nonzero outside ACCESS.

Decomposition:
- Package mem_pkg holds:
  - MEMOP_IDLE = 0, MEMOP_READ = 1, MEMOP_WRITE = 2;
  - the state enum {IDLE, ACCESS, RESP};
  - default widths.
- One sub-module, rr_arb2: combinational two-way picker with inputs req0, req1, last_grant, fixed_prio and outputs valid, winner.
- The FSM, wait counter and datapath latches live in mem_arbiter.

Test Plan:
- Reset, then req0 read of addr 0x400000 with memindata = 0x3C010040 and WAIT_STATES = 0 -> memop = 1 for exactly one cycle; ack0 three cycles after req0 is sampled; rdata0 = 0x3C010040; ack1 never asserts.
- req1 write of 0xDEADBEEF to 0x10010000 -> memop = 2, memaddress = 0x10010000, memoutdata = 0xDEADBEEF for one cycle; then ack1 with err1 = 0.
- req0 and req1 held high for 4 transactions with FIXED_PRIO = 0 -> grant order 0,1,0,1. Repeat with FIXED_PRIO = 1 -> port 0 served every time while it requests.
- WAIT_STATES = 3, read -> memop = 1 for 4 consecutive cycles; ack after 6 cycles; rdata equals memindata from the last ACCESS cycle.
- op0 = 3 -> memop stays 0 throughout; ack0 and err0 pulse together for one cycle.
- rst pulled low during ACCESS -> memop = 0 without waiting for a clock edge; no ack. After release, a fresh req0 completes normally.
